// File: rtl/bcd_seg_display.sv
// Four-digit multiplexed seven-segment driver for a common-anode display.
// Scans the captured BCD digits with a per-slot anode-off guard band.
module bcd_seg_display #(
  parameter int REFRESH_DIV  = 100000,
  parameter int BLANK_CYCLES = 1000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] Hundreds,
  input  logic [3:0] Tens,
  input  logic [3:0] Ones,
  input  logic       Load,
  input  logic       LZB,
  output logic [6:0] Seg,
  output logic [3:0] An,
  output logic       Frame
);

  localparam int CW = $clog2(REFRESH_DIV);
  localparam logic [CW-1:0] LAST = CW'(REFRESH_DIV - 1);
  localparam logic [CW-1:0] BLK  = CW'(BLANK_CYCLES);

  typedef enum logic [1:0] {DIG0, DIG1, DIG2, DIG3} slot_t;

  slot_t         r_state;
  logic [CW-1:0] r_cnt;
  logic [9:0]    r_hold;
  logic [9:0]    r_snap;

  logic          w_wrap;
  slot_t         w_state_nxt;
  logic [CW-1:0] w_cnt_nxt;
  logic [9:0]    w_snap_nxt;
  logic [3:0]    w_digit;
  logic          w_blank;
  logic [6:0]    w_seg_nxt;
  logic [3:0]    w_an_nxt;
  logic          w_frame_nxt;

  function automatic logic [6:0] seg_decode(input logic [3:0] d);
    case (d)
      4'd0:    seg_decode = 7'b1000000;
      4'd1:    seg_decode = 7'b1111001;
      4'd2:    seg_decode = 7'b0100100;
      4'd3:    seg_decode = 7'b0110000;
      4'd4:    seg_decode = 7'b0011001;
      4'd5:    seg_decode = 7'b0010010;
      4'd6:    seg_decode = 7'b0000010;
      4'd7:    seg_decode = 7'b1111000;
      4'd8:    seg_decode = 7'b0000000;
      4'd9:    seg_decode = 7'b0010000;
      default: seg_decode = 7'b0111111;
    endcase
  endfunction

  assign w_wrap     = (r_cnt == LAST);
  assign w_cnt_nxt  = w_wrap ? '0 : r_cnt + 1'b1;
  // The snapshot reads the hold register before this edge's Load lands.
  assign w_snap_nxt = w_wrap ? r_hold : r_snap;

  always_comb begin
    w_state_nxt = r_state;
    if (w_wrap) begin
      case (r_state)
        DIG0:    w_state_nxt = DIG1;
        DIG1:    w_state_nxt = DIG2;
        DIG2:    w_state_nxt = DIG3;
        default: w_state_nxt = DIG0;
      endcase
    end
  end

  always_comb begin
    w_digit = w_snap_nxt[3:0];
    w_blank = 1'b0;
    w_an_nxt = 4'hF;
    case (w_state_nxt)
      DIG0: begin
        w_digit  = w_snap_nxt[3:0];
        w_an_nxt = 4'b1110;
      end
      DIG1: begin
        w_digit  = w_snap_nxt[7:4];
        w_blank  = LZB && (w_snap_nxt[9:8] == 2'd0) && (w_snap_nxt[7:4] == 4'd0);
        w_an_nxt = 4'b1101;
      end
      DIG2: begin
        w_digit  = {2'b00, w_snap_nxt[9:8]};
        w_blank  = LZB && (w_snap_nxt[9:8] == 2'd0);
        w_an_nxt = 4'b1011;
      end
      default: begin
        w_blank  = 1'b1;
        w_an_nxt = 4'hF;
      end
    endcase
    if (w_cnt_nxt < BLK) w_an_nxt = 4'hF;
  end

  assign w_seg_nxt   = w_blank ? 7'h7F : seg_decode(w_digit);
  assign w_frame_nxt = (w_state_nxt == DIG3) && (w_cnt_nxt == LAST);

  // Outputs are computed from next-state values so they track (state, cnt)
  // in the same cycle while remaining purely registered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= DIG0;
      r_cnt   <= '0;
      r_hold  <= '0;
      r_snap  <= '0;
      Seg     <= 7'h7F;
      An      <= 4'hF;
      Frame   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_snap  <= w_snap_nxt;
      if (Load) r_hold <= {Hundreds, Tens, Ones};
      Seg     <= w_seg_nxt;
      An      <= w_an_nxt;
      Frame   <= w_frame_nxt;
    end
  end

endmodule
